getir_denetleyici: RTL and testbench

- Fetch-stage controller that sequences the program counter and the instruction-memory request/response handshake, and feeds each fetched 32-bit word into the instruction queue (buyruk_kuyrugu).
- Handles branch redirects, aligned and misaligned targets, the queue's compressed-pair hold (ps_durdur) and back-end stalls.
- Sits between the instruction cache/memory port and the instruction queue.

---
 rtl/getir_denetleyici.sv | 209 ++++++++++++++++++++
 tb/tb_getir_denetleyici.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/getir_denetleyici.sv
// getir_denetleyici: fetch-stage controller.
// Sequences the fetch PC, runs the instruction-memory request/response
// handshake and hands each fetched 32-bit word to the instruction queue.
// Optional build macro: GETIR_ZAMAN_ASIMI_EN (response timeout with hata_o pulse).
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOSTA  | idle after reset, no request
// ISTEK  | request valid, address held until accepted
// BEKLE  | request accepted, waiting for the response word
// TUT    | response captured during back-end stall, waiting to deliver
// BOSLUK | one idle slot so the queue can drain its held compressed half
// IPTAL  | redirected while a response is outstanding, discard it
module getir_denetleyici #(
    parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000,
    parameter int          ZAMAN_ASIMI  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_veri_gecerli_i,
    input  logic [31:0] bellek_veri_i,
    output logic        kuyruk_aktif_o,
    output logic [31:0] kuyruk_buyruk_o,
    output logic [31:0] kuyruk_ps_o,
    output logic        ps_atladi_o,
    input  logic        ps_durdur_i,
    input  logic        ps_iki_artir_i,
    input  logic        durdur_i,
    input  logic        dallanma_gecerli_i,
    input  logic [31:0] dallanma_ps_i,
    output logic [31:0] getir_ps_o,
    output logic        bekliyor_o,
    output logic        hata_o
);

    typedef enum logic [2:0] {
        BOSTA  = 3'd0,
        ISTEK  = 3'd1,
        BEKLE  = 3'd2,
        TUT    = 3'd3,
        BOSLUK = 3'd4,
        IPTAL  = 3'd5
    } durum_t;

    durum_t      r_durum;
    durum_t      w_sonraki;
    logic [31:0] r_ps;
    logic [31:0] w_ps_sonraki;
    logic [31:0] r_tut;
    logic        w_yakala;
    logic        w_teslim;
    logic [31:0] w_teslim_veri;
    logic [31:0] w_hizali_ps;
    logic        w_zaman_doldu;

    assign w_hizali_ps = {r_ps[31:2], 2'b00};
    assign getir_ps_o  = r_ps;

`ifdef GETIR_ZAMAN_ASIMI_EN
    localparam int                SAYAC_W   = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SAYAC_W-1:0] SAYAC_YUK = SAYAC_W'(ZAMAN_ASIMI - 1);

    logic [SAYAC_W-1:0] r_sayac;
    logic               w_bekleme;

    assign w_bekleme     = (r_durum == BEKLE) || (r_durum == IPTAL);
    assign w_zaman_doldu = w_bekleme && (r_sayac == '0) && !bellek_veri_gecerli_i;
    // A redirect wins over a timeout in the same cycle, so no error is raised then.
    assign hata_o        = w_zaman_doldu && !dallanma_gecerli_i;

    // Down-counter over one uninterrupted wait; reloaded whenever the wait ends or restarts.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_sayac <= SAYAC_YUK;
        end else if (w_bekleme && (w_sonraki == r_durum) && !dallanma_gecerli_i) begin
            r_sayac <= r_sayac - SAYAC_W'(1);
        end else begin
            r_sayac <= SAYAC_YUK;
        end
    end
`else
    logic w_unused_zaman;

    assign w_unused_zaman = (ZAMAN_ASIMI != 0);
    assign w_zaman_doldu  = 1'b0;
    assign hata_o         = 1'b0;
`endif

    // State, PC and hold-register update.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_durum <= BOSTA;
            r_ps    <= BASLANGIC_PS;
            r_tut   <= '0;
        end else begin
            r_durum <= w_sonraki;
            r_ps    <= w_ps_sonraki;
            if (w_yakala) begin
                r_tut <= bellek_veri_i;
            end
        end
    end

    // Next state, next PC and all handshake outputs; redirect overrides delivery.
    always_comb begin
        w_sonraki       = r_durum;
        w_ps_sonraki    = r_ps;
        w_yakala        = 1'b0;
        w_teslim        = 1'b0;
        w_teslim_veri   = '0;
        bellek_istek_o  = 1'b0;
        bellek_adres_o  = '0;
        bekliyor_o      = 1'b0;
        kuyruk_aktif_o  = 1'b0;
        kuyruk_buyruk_o = '0;
        kuyruk_ps_o     = '0;
        ps_atladi_o     = 1'b0;

        case (r_durum)
            BOSTA: begin
                w_sonraki = ISTEK;
            end
            ISTEK: begin
                bellek_istek_o = 1'b1;
                bellek_adres_o = w_hizali_ps;
                if (bellek_hazir_i) begin
                    w_sonraki = BEKLE;
                end
            end
            BEKLE: begin
                bekliyor_o = 1'b1;
                if (bellek_veri_gecerli_i) begin
                    if (durdur_i) begin
                        w_yakala  = 1'b1;
                        w_sonraki = TUT;
                    end else begin
                        w_teslim      = 1'b1;
                        w_teslim_veri = bellek_veri_i;
                    end
                end else if (w_zaman_doldu) begin
                    w_sonraki = ISTEK;
                end
            end
            TUT: begin
                if (!durdur_i) begin
                    w_teslim      = 1'b1;
                    w_teslim_veri = r_tut;
                end
            end
            BOSLUK: begin
                w_sonraki = ISTEK;
            end
            IPTAL: begin
                bekliyor_o = 1'b1;
                if (bellek_veri_gecerli_i || w_zaman_doldu) begin
                    w_sonraki = ISTEK;
                end
            end
            default: begin
                w_sonraki = BOSTA;
            end
        endcase

        if (dallanma_gecerli_i) begin
            ps_atladi_o  = 1'b1;
            kuyruk_ps_o  = dallanma_ps_i;
            w_ps_sonraki = dallanma_ps_i;
            w_yakala     = 1'b0;
            case (r_durum)
                BEKLE, IPTAL: begin
                    if (bellek_veri_gecerli_i) begin
                        w_sonraki = ISTEK;
                    end else begin
                        w_sonraki = IPTAL;
                    end
                end
                ISTEK: begin
                    // An accepted old-address request still owes us a response.
                    if (bellek_hazir_i) begin
                        w_sonraki = IPTAL;
                    end else begin
                        w_sonraki = ISTEK;
                    end
                end
                default: begin
                    w_sonraki = ISTEK;
                end
            endcase
        end else if (w_teslim) begin
            kuyruk_aktif_o  = 1'b1;
            kuyruk_buyruk_o = w_teslim_veri;
            kuyruk_ps_o     = r_ps;
            if (ps_iki_artir_i) begin
                w_ps_sonraki = r_ps + 32'd2;
            end else begin
                w_ps_sonraki = w_hizali_ps + 32'd4;
            end
            if (ps_durdur_i) begin
                w_sonraki = BOSLUK;
            end else begin
                w_sonraki = ISTEK;
            end
        end
    end

endmodule

// File: tb/tb_getir_denetleyici.sv
// Testbench for getir_denetleyici: directed scenarios followed by a randomized
// run checked against a transaction-level model of the fetch behaviour.
module tb_getir_denetleyici;

    localparam logic [31:0] BPS = 32'h4000_0000;
    localparam int          ZA  = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        bellek_hazir_i;
    logic        bellek_veri_gecerli_i;
    logic [31:0] bellek_veri_i;
    logic        kuyruk_aktif_o;
    logic [31:0] kuyruk_buyruk_o;
    logic [31:0] kuyruk_ps_o;
    logic        ps_atladi_o;
    logic        ps_durdur_i;
    logic        ps_iki_artir_i;
    logic        durdur_i;
    logic        dallanma_gecerli_i;
    logic [31:0] dallanma_ps_i;
    logic [31:0] getir_ps_o;
    logic        bekliyor_o;
    logic        hata_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    getir_denetleyici #(.BASLANGIC_PS(BPS), .ZAMAN_ASIMI(ZA)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .bellek_istek_o        (bellek_istek_o),
        .bellek_adres_o        (bellek_adres_o),
        .bellek_hazir_i        (bellek_hazir_i),
        .bellek_veri_gecerli_i (bellek_veri_gecerli_i),
        .bellek_veri_i         (bellek_veri_i),
        .kuyruk_aktif_o        (kuyruk_aktif_o),
        .kuyruk_buyruk_o       (kuyruk_buyruk_o),
        .kuyruk_ps_o           (kuyruk_ps_o),
        .ps_atladi_o           (ps_atladi_o),
        .ps_durdur_i           (ps_durdur_i),
        .ps_iki_artir_i        (ps_iki_artir_i),
        .durdur_i              (durdur_i),
        .dallanma_gecerli_i    (dallanma_gecerli_i),
        .dallanma_ps_i         (dallanma_ps_i),
        .getir_ps_o            (getir_ps_o),
        .bekliyor_o            (bekliyor_o),
        .hata_o                (hata_o)
    );

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bellek_hazir_i        = 1'b0;
        bellek_veri_gecerli_i = 1'b0;
        bellek_veri_i         = '0;
        ps_durdur_i           = 1'b0;
        ps_iki_artir_i        = 1'b0;
        durdur_i              = 1'b0;
        dallanma_gecerli_i    = 1'b0;
        dallanma_ps_i         = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        nxt(); #1;
        checks++; if (bellek_istek_o !== 1'b0) begin errors++; $display("FAIL rst_istek: got %0b want 0", bellek_istek_o); end
        checks++; if (bellek_adres_o !== 32'h0) begin errors++; $display("FAIL rst_adres: got %h want 0", bellek_adres_o); end
        checks++; if (kuyruk_aktif_o !== 1'b0) begin errors++; $display("FAIL rst_aktif: got %0b want 0", kuyruk_aktif_o); end
        checks++; if (kuyruk_buyruk_o !== 32'h0) begin errors++; $display("FAIL rst_buyruk: got %h want 0", kuyruk_buyruk_o); end
        checks++; if (kuyruk_ps_o !== 32'h0) begin errors++; $display("FAIL rst_kps: got %h want 0", kuyruk_ps_o); end
        checks++; if (ps_atladi_o !== 1'b0) begin errors++; $display("FAIL rst_atladi: got %0b want 0", ps_atladi_o); end
        checks++; if (getir_ps_o !== BPS) begin errors++; $display("FAIL rst_ps: got %h want %h", getir_ps_o, BPS); end
        checks++; if (bekliyor_o !== 1'b0) begin errors++; $display("FAIL rst_bekliyor: got %0b want 0", bekliyor_o); end
        checks++; if (hata_o !== 1'b0) begin errors++; $display("FAIL rst_hata: got %0b want 0", hata_o); end
        nxt(); rst_i = 1'b1; #1;
        checks++; if (bellek_istek_o !== 1'b0) begin errors++; $display("FAIL rst_bosta: got %0b want 0", bellek_istek_o); end
    endtask

    task automatic test_basic();
        nxt(); bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== BPS) begin errors++; $display("FAIL basic_req0: got %0b/%h want 1/%h", bellek_istek_o, bellek_adres_o, BPS); end
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h0000_0013; #1;
        checks++; if (bekliyor_o !== 1'b1) begin errors++; $display("FAIL basic_bekliyor: got %0b want 1", bekliyor_o); end
        checks++; if (kuyruk_aktif_o !== 1'b1 || kuyruk_buyruk_o !== 32'h13 || kuyruk_ps_o !== BPS) begin errors++; $display("FAIL basic_del0: got %0b/%h/%h want 1/00000013/%h", kuyruk_aktif_o, kuyruk_buyruk_o, kuyruk_ps_o, BPS); end
        nxt(); bellek_veri_gecerli_i = 1'b0; bellek_veri_i = '0; bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_0004) begin errors++; $display("FAIL basic_req1: got %0b/%h want 1/40000004", bellek_istek_o, bellek_adres_o); end
        checks++; if (kuyruk_aktif_o !== 1'b0) begin errors++; $display("FAIL basic_noact: got %0b want 0", kuyruk_aktif_o); end
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h0000_0013; #1;
        checks++; if (kuyruk_aktif_o !== 1'b1 || kuyruk_ps_o !== 32'h4000_0004) begin errors++; $display("FAIL basic_del1: got %0b/%h want 1/40000004", kuyruk_aktif_o, kuyruk_ps_o); end
    endtask

    task automatic test_ps_durdur();
        nxt(); bellek_veri_gecerli_i = 1'b0; bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_0008) begin errors++; $display("FAIL psd_req: got %0b/%h want 1/40000008", bellek_istek_o, bellek_adres_o); end
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h0000_4501; ps_durdur_i = 1'b1; #1;
        checks++; if (kuyruk_aktif_o !== 1'b1 || kuyruk_ps_o !== 32'h4000_0008) begin errors++; $display("FAIL psd_del: got %0b/%h want 1/40000008", kuyruk_aktif_o, kuyruk_ps_o); end
        nxt(); bellek_veri_gecerli_i = 1'b0; ps_durdur_i = 1'b0; bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_istek_o !== 1'b0) begin errors++; $display("FAIL psd_gap: got %0b want 0", bellek_istek_o); end
        checks++; if (getir_ps_o !== 32'h4000_000C) begin errors++; $display("FAIL psd_ps: got %h want 4000000c", getir_ps_o); end
        nxt(); bellek_hazir_i = 1'b0; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_000C) begin errors++; $display("FAIL psd_req2: got %0b/%h want 1/4000000c", bellek_istek_o, bellek_adres_o); end
    endtask

    task automatic test_misaligned();
        nxt(); dallanma_gecerli_i = 1'b1; dallanma_ps_i = 32'h4000_0102; #1;
        checks++; if (ps_atladi_o !== 1'b1 || kuyruk_ps_o !== 32'h4000_0102 || kuyruk_aktif_o !== 1'b0) begin errors++; $display("FAIL mis_redir: got %0b/%h/%0b want 1/40000102/0", ps_atladi_o, kuyruk_ps_o, kuyruk_aktif_o); end
        nxt(); dallanma_gecerli_i = 1'b0; dallanma_ps_i = '0; bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_0100) begin errors++; $display("FAIL mis_addr: got %0b/%h want 1/40000100", bellek_istek_o, bellek_adres_o); end
        checks++; if (getir_ps_o !== 32'h4000_0102 || ps_atladi_o !== 1'b0) begin errors++; $display("FAIL mis_ps: got %h/%0b want 40000102/0", getir_ps_o, ps_atladi_o); end
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hCAFE_0001; ps_iki_artir_i = 1'b1; #1;
        checks++; if (kuyruk_aktif_o !== 1'b1 || kuyruk_ps_o !== 32'h4000_0102 || kuyruk_buyruk_o !== 32'hCAFE_0001) begin errors++; $display("FAIL mis_del: got %0b/%h/%h want 1/40000102/cafe0001", kuyruk_aktif_o, kuyruk_ps_o, kuyruk_buyruk_o); end
        nxt(); bellek_veri_gecerli_i = 1'b0; ps_iki_artir_i = 1'b0; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_0104) begin errors++; $display("FAIL mis_next: got %0b/%h want 1/40000104", bellek_istek_o, bellek_adres_o); end
    endtask

    task automatic test_redirect_bekle();
        nxt(); bellek_hazir_i = 1'b1; #1;
        nxt(); bellek_hazir_i = 1'b0; dallanma_gecerli_i = 1'b1; dallanma_ps_i = 32'h4000_0200; #1;
        checks++; if (ps_atladi_o !== 1'b1 || bekliyor_o !== 1'b1) begin errors++; $display("FAIL rb_redir: got %0b/%0b want 1/1", ps_atladi_o, bekliyor_o); end
        for (int i = 0; i < 2; i++) begin
            nxt(); dallanma_gecerli_i = 1'b0; dallanma_ps_i = '0; #1;
            checks++; if (bekliyor_o !== 1'b1 || bellek_istek_o !== 1'b0 || getir_ps_o !== 32'h4000_0200) begin errors++; $display("FAIL rb_wait%0d: got %0b/%0b/%h want 1/0/40000200", i, bekliyor_o, bellek_istek_o, getir_ps_o); end
        end
        nxt(); bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'hDEAD_BEEF; ps_durdur_i = 1'b1; #1;
        checks++; if (kuyruk_aktif_o !== 1'b0 || kuyruk_buyruk_o !== 32'h0) begin errors++; $display("FAIL rb_stale: got %0b/%h want 0/0", kuyruk_aktif_o, kuyruk_buyruk_o); end
        nxt(); bellek_veri_gecerli_i = 1'b0; bellek_veri_i = '0; ps_durdur_i = 1'b0; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_0200) begin errors++; $display("FAIL rb_next: got %0b/%h want 1/40000200", bellek_istek_o, bellek_adres_o); end
    endtask

    task automatic test_durdur_hold();
        nxt(); bellek_hazir_i = 1'b1; #1;
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h1234_5678; durdur_i = 1'b1; #1;
        checks++; if (kuyruk_aktif_o !== 1'b0) begin errors++; $display("FAIL hold_c0: got %0b want 0", kuyruk_aktif_o); end
        for (int i = 1; i < 4; i++) begin
            nxt(); bellek_veri_gecerli_i = 1'b0; bellek_veri_i = '0; #1;
            checks++; if (kuyruk_aktif_o !== 1'b0 || kuyruk_buyruk_o !== 32'h0) begin errors++; $display("FAIL hold_c%0d: got %0b/%h want 0/0", i, kuyruk_aktif_o, kuyruk_buyruk_o); end
        end
        nxt(); durdur_i = 1'b0; #1;
        checks++; if (kuyruk_aktif_o !== 1'b1 || kuyruk_buyruk_o !== 32'h1234_5678 || kuyruk_ps_o !== 32'h4000_0200) begin errors++; $display("FAIL hold_del: got %0b/%h/%h want 1/12345678/40000200", kuyruk_aktif_o, kuyruk_buyruk_o, kuyruk_ps_o); end
        nxt(); bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_adres_o !== 32'h4000_0204) begin errors++; $display("FAIL hold_addr: got %h want 40000204", bellek_adres_o); end
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h0BAD_F00D; durdur_i = 1'b1; #1;
        nxt(); bellek_veri_gecerli_i = 1'b0; bellek_veri_i = '0; dallanma_gecerli_i = 1'b1; dallanma_ps_i = 32'h4000_0300; #1;
        checks++; if (ps_atladi_o !== 1'b1 || kuyruk_aktif_o !== 1'b0) begin errors++; $display("FAIL tut_redir: got %0b/%0b want 1/0", ps_atladi_o, kuyruk_aktif_o); end
        nxt(); dallanma_gecerli_i = 1'b0; dallanma_ps_i = '0; #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_0300 || kuyruk_aktif_o !== 1'b0) begin errors++; $display("FAIL tut_req: got %0b/%h/%0b want 1/40000300/0", bellek_istek_o, bellek_adres_o, kuyruk_aktif_o); end
        nxt(); durdur_i = 1'b0; #1;
        checks++; if (kuyruk_aktif_o !== 1'b0 || bellek_istek_o !== 1'b1) begin errors++; $display("FAIL tut_drop: got %0b/%0b want 0/1", kuyruk_aktif_o, bellek_istek_o); end
    endtask

    task automatic test_timeout();
        nxt(); bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_adres_o !== 32'h4000_0300) begin errors++; $display("FAIL to_addr: got %h want 40000300", bellek_adres_o); end
`ifdef GETIR_ZAMAN_ASIMI_EN
        for (int k = 1; k <= ZA; k++) begin
            nxt(); bellek_hazir_i = 1'b0; #1;
            checks++; if (hata_o !== (k == ZA) || bekliyor_o !== 1'b1) begin errors++; $display("FAIL to_cyc%0d: got %0b/%0b want %0b/1", k, hata_o, bekliyor_o, (k == ZA)); end
        end
        nxt(); #1;
        checks++; if (bellek_istek_o !== 1'b1 || bellek_adres_o !== 32'h4000_0300 || hata_o !== 1'b0) begin errors++; $display("FAIL to_reissue: got %0b/%h/%0b want 1/40000300/0", bellek_istek_o, bellek_adres_o, hata_o); end
        bellek_hazir_i = 1'b1;
`else
        for (int k = 1; k <= 20; k++) begin
            nxt(); bellek_hazir_i = 1'b0; #1;
            checks++; if (hata_o !== 1'b0 || bekliyor_o !== 1'b1 || bellek_istek_o !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got %0b/%0b/%0b want 0/1/0", k, hata_o, bekliyor_o, bellek_istek_o); end
        end
`endif
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h0000_0300; #1;
        checks++; if (kuyruk_aktif_o !== 1'b1 || kuyruk_ps_o !== 32'h4000_0300) begin errors++; $display("FAIL to_del: got %0b/%h want 1/40000300", kuyruk_aktif_o, kuyruk_ps_o); end
        nxt(); bellek_veri_gecerli_i = 1'b0; bellek_veri_i = '0; #1;
    endtask

    task automatic test_wrap();
        nxt(); dallanma_gecerli_i = 1'b1; dallanma_ps_i = 32'hFFFF_FFFC; #1;
        nxt(); dallanma_gecerli_i = 1'b0; dallanma_ps_i = '0; bellek_hazir_i = 1'b1; #1;
        checks++; if (bellek_adres_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", bellek_adres_o); end
        nxt(); bellek_hazir_i = 1'b0; bellek_veri_gecerli_i = 1'b1; bellek_veri_i = 32'h7777_0000; #1;
        checks++; if (kuyruk_aktif_o !== 1'b1 || kuyruk_ps_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_del: got %0b/%h want 1/fffffffc", kuyruk_aktif_o, kuyruk_ps_o); end
        nxt(); bellek_veri_gecerli_i = 1'b0; bellek_veri_i = '0; #1;
        checks++; if (getir_ps_o !== 32'h0 || bellek_adres_o !== 32'h0 || bellek_istek_o !== 1'b1) begin errors++; $display("FAIL wrap_ps: got %h/%h/%0b want 0/0/1", getir_ps_o, bellek_adres_o, bellek_istek_o); end
    endtask

    task automatic test_reset_mid();
        nxt(); bellek_hazir_i = 1'b1; #1;
        nxt(); bellek_hazir_i = 1'b0; rst_i = 1'b0; #1;
        checks++; if (bekliyor_o !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %0b want 1", bekliyor_o); end
        nxt(); rst_i = 1'b1; #1;
        checks++; if (bekliyor_o !== 1'b0 || bellek_istek_o !== 1'b0 || getir_ps_o !== BPS) begin errors++; $display("FAIL rmid_post: got %0b/%0b/%h want 0/0/%h", bekliyor_o, bellek_istek_o, getir_ps_o, BPS); end
    endtask

    // Transaction-level model: tracks the expected PC, whether memory owes a
    // response (and whether that response is obsolete), a word parked by a
    // back-end stall, and the single idle slot after a held compressed pair.
    task automatic test_random();
        logic [31:0] m_pc   = BPS;
        bit          m_pend = 0;
        bit          m_stale = 0;
        bit          m_have = 0;
        logic [31:0] m_word = '0;
        bit          m_gap  = 0;
        int          mem_wait = 0;
        int          n_del = 0;
        for (int c = 0; c < 4000; c++) begin
            bit          red, hz, dd, pd, ia, resp, req_e, del_e, acc;
            logic [31:0] tgt, wd, word_e, kps_e;
            nxt();
            red = ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            tgt[0] = 1'b0;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
            hz = 1'($urandom_range(0, 1));
            dd = ($urandom_range(0, 2) == 0);
            pd = ($urandom_range(0, 3) == 0);
            ia = m_pc[1] ? 1'($urandom_range(0, 1)) : 1'b0;
            resp = 1'b0;
            if (m_pend) begin
                if (mem_wait == 0) resp = 1'b1;
                else mem_wait--;
            end
            wd = $urandom;
            bellek_hazir_i = hz; bellek_veri_gecerli_i = resp; bellek_veri_i = wd;
            durdur_i = dd; ps_durdur_i = pd; ps_iki_artir_i = ia;
            dallanma_gecerli_i = red; dallanma_ps_i = tgt;
            #1;
            req_e  = !m_pend && !m_have && !m_gap;
            del_e  = !red && !dd && ((resp && !m_stale) || m_have);
            word_e = m_have ? m_word : wd;
            kps_e  = red ? tgt : (del_e ? m_pc : 32'h0);
            checks++; if (getir_ps_o !== m_pc) begin errors++; $display("FAIL rnd_ps c%0d: got %h want %h", c, getir_ps_o, m_pc); end
            checks++; if (bellek_istek_o !== req_e) begin errors++; $display("FAIL rnd_istek c%0d: got %0b want %0b", c, bellek_istek_o, req_e); end
            if (req_e) begin
                checks++; if (bellek_adres_o !== {m_pc[31:2], 2'b00}) begin errors++; $display("FAIL rnd_adres c%0d: got %h want %h", c, bellek_adres_o, {m_pc[31:2], 2'b00}); end
            end
            checks++; if (bekliyor_o !== m_pend) begin errors++; $display("FAIL rnd_bekliyor c%0d: got %0b want %0b", c, bekliyor_o, m_pend); end
            checks++; if (kuyruk_aktif_o !== del_e) begin errors++; $display("FAIL rnd_aktif c%0d: got %0b want %0b", c, kuyruk_aktif_o, del_e); end
            checks++; if (kuyruk_buyruk_o !== (del_e ? word_e : 32'h0)) begin errors++; $display("FAIL rnd_buyruk c%0d: got %h want %h", c, kuyruk_buyruk_o, (del_e ? word_e : 32'h0)); end
            checks++; if (ps_atladi_o !== red) begin errors++; $display("FAIL rnd_atladi c%0d: got %0b want %0b", c, ps_atladi_o, red); end
            if (red || del_e) begin
                checks++; if (kuyruk_ps_o !== kps_e) begin errors++; $display("FAIL rnd_kps c%0d: got %h want %h", c, kuyruk_ps_o, kps_e); end
            end
            checks++; if (hata_o !== 1'b0) begin errors++; $display("FAIL rnd_hata c%0d: got %0b want 0", c, hata_o); end

            acc = req_e && hz;
            if (acc) mem_wait = $urandom_range(0, 2);
            m_gap = 1'b0;
            if (red) begin
                m_pc   = tgt;
                m_have = 1'b0;
                if (acc) begin
                    m_pend = 1'b1; m_stale = 1'b1;
                end else if (m_pend && !resp) begin
                    m_stale = 1'b1;
                end else if (resp) begin
                    m_pend = 1'b0;
                end
            end else begin
                if (acc) begin
                    m_pend = 1'b1; m_stale = 1'b0;
                end
                if (resp) begin
                    m_pend = 1'b0;
                    if (!m_stale && dd) begin
                        m_have = 1'b1; m_word = wd;
                    end
                end
                if (del_e) begin
                    n_del++;
                    m_have = 1'b0;
                    m_pc   = ia ? m_pc + 32'd2 : {m_pc[31:2], 2'b00} + 32'd4;
                    m_gap  = pd;
                end
            end
        end
        checks++; if (n_del < 100) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >=100", n_del); end
        nxt(); idle_inputs(); #1;
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_ps_durdur();
        test_misaligned();
        test_redirect_bekle();
        test_durdur_hold();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
